// File: rtl/banked_sync_ram.sv
// banked_sync_ram: byte-lane writable word RAM split into 2^BANK_BITS banks, zero-filled by a power-on sweep.
// Latency: reads return one cycle after acceptance; writes complete in the accepting cycle; init sweep takes 2^(ADDR_WIDTH-BANK_BITS) cycles.
// Backpressure: req_ready drops while a read response is held by !rsp_ready and throughout the init sweep.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   req_valid/req_ready           request handshake; req_we selects write (1) or read (0)
//   req_addr, req_wdata, req_be   word address, write data, per-lane write enables
//   rsp_valid/rsp_ready, rsp_rdata  registered read response, held while stalled
//   init_done                     zero-fill sweep finished
//   bank_act                      one-hot bank touched by the previous cycle's accepted request
module banked_sync_ram #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int LANE_WIDTH = 8,
    parameter int BANK_BITS  = 2,
    parameter int INTERLEAVE = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_we,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] req_be,
    output logic                             rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    input  logic                             rsp_ready,
    output logic                             init_done,
    output logic [(1<<BANK_BITS)-1:0]        bank_act
);

    localparam int LANES     = DATA_WIDTH / LANE_WIDTH;
    localparam int NUM_BANKS = 1 << BANK_BITS;
    localparam int ROW_BITS  = ADDR_WIDTH - BANK_BITS;
    localparam int ROWS      = 1 << ROW_BITS;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_q;
    logic [ROW_BITS-1:0]     row_q;
    logic                    init_done_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic [NUM_BANKS-1:0]    bank_act_q;

    logic [BANK_BITS-1:0]    req_bank;
    logic [ROW_BITS-1:0]     req_row;
    logic [NUM_BANKS-1:0]    bank_onehot_d;
    logic [DATA_WIDTH-1:0]   wmask;
    logic [DATA_WIDTH-1:0]   bank_rdata [NUM_BANKS];
    logic                    accept;

    // Split the word address into bank and row; the row keeps the remaining bits in order.
    always_comb begin
        if (INTERLEAVE != 0) begin
            req_bank = req_addr[BANK_BITS-1:0];
            req_row  = req_addr[ADDR_WIDTH-1:BANK_BITS];
        end else begin
            req_bank = req_addr[ADDR_WIDTH-1 -: BANK_BITS];
            req_row  = req_addr[ROW_BITS-1:0];
        end
        bank_onehot_d           = '0;
        bank_onehot_d[req_bank] = 1'b1;
    end

    // A held response blocks new requests; reset also blocks so nothing is accepted in a reset cycle.
    assign req_ready = (state_q == ST_RUN) && !rst && !(rsp_valid_q && !rsp_ready);
    assign accept    = req_valid && req_ready;

    // Expand per-lane enables into a bit mask for the read-modify-write merge.
    for (genvar l = 0; l < LANES; l++) begin : g_mask
        assign wmask[l*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{req_be[l]}};
    end

    // Storage banks: the init sweep zeroes the same row in every bank each cycle.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem_q [ROWS];

        always_ff @(posedge clk) begin
            if (state_q == ST_INIT) begin
                mem_q[row_q] <= '0;
            end else if (accept && req_we && bank_onehot_d[b]) begin
                mem_q[req_row] <= (mem_q[req_row] & ~wmask) | (req_wdata & wmask);
            end
        end

        assign bank_rdata[b] = mem_q[req_row];
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            row_q       <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            bank_act_q  <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    bank_act_q <= '0;
                    row_q      <= row_q + ROW_BITS'(1);
                    if (row_q == {ROW_BITS{1'b1}}) begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    bank_act_q <= accept ? bank_onehot_d : '0;
                    if (accept && !req_we) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= bank_rdata[req_bank];
                    end else if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign init_done = init_done_q;
    assign bank_act  = bank_act_q;

endmodule

// File: tb/tb_banked_sync_ram.sv
// Directed bench for banked_sync_ram: two instances (block and interleaved mapping) share one stimulus stream.
// Vectors are applied one per cycle; multi-cycle corner cases use hand-written sequences.
// Outputs are sampled 2 time units after the rising edge.
module tb_banked_sync_ram;

    localparam int AW    = 6;
    localparam int DW    = 16;
    localparam int LW    = 8;
    localparam int BB    = 2;
    localparam int LANES = DW / LW;
    localparam int NB    = 1 << BB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             req_valid;
    logic             req_we;
    logic [AW-1:0]    req_addr;
    logic [DW-1:0]    req_wdata;
    logic [LANES-1:0] req_be;
    logic             rsp_ready;

    logic             req_ready0, rsp_valid0, init_done0;
    logic [DW-1:0]    rsp_rdata0;
    logic [NB-1:0]    bank_act0;
    logic             req_ready1, rsp_valid1, init_done1;
    logic [DW-1:0]    rsp_rdata1;
    logic [NB-1:0]    bank_act1;

    banked_sync_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(LW), .BANK_BITS(BB), .INTERLEAVE(0)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready0), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid0),
        .rsp_rdata(rsp_rdata0), .rsp_ready(rsp_ready), .init_done(init_done0), .bank_act(bank_act0)
    );

    banked_sync_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(LW), .BANK_BITS(BB), .INTERLEAVE(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid1),
        .rsp_rdata(rsp_rdata1), .rsp_ready(rsp_ready), .init_done(init_done1), .bank_act(bank_act1)
    );

    typedef struct {
        logic             we;
        logic [AW-1:0]    addr;
        logic [DW-1:0]    wdata;
        logic [LANES-1:0] be;
        logic [DW-1:0]    exp;
        logic [NB-1:0]    act0;
        logic [NB-1:0]    act1;
    } vec_t;

    vec_t vt [13];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [LANES-1:0] be);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
    endtask

    // Counts edges after reset release until init_done; a read is offered throughout and must not be taken.
    task automatic wait_init(input string tag);
        int n    = 0;
        int viol = 0;
        drive(1'b0, 6'd0, 16'h0, 2'b00);
        while (!init_done0 && n < 40) begin
            #1;
            if (req_ready0 || req_ready1 || rsp_valid0) viol++;
            step();
            n++;
        end
        idle();
        chk({tag, " init cycles"}, 32'(n), 32'd16);
        chk({tag, " no accept during init"}, 32'(viol), 32'd0);
        chk({tag, " init_done interleaved"}, 32'(init_done1), 32'd1);
        #1;
        chk({tag, " req_ready after init"}, 32'(req_ready0), 32'd1);
    endtask

    // 64 back-to-back reads; every cycle must carry the response of the read just accepted.
    task automatic stream_read(input bit pattern, input string tag);
        logic [DW-1:0] exp;
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, AW'(i), 16'h0, 2'b00);
            step();
            exp = pattern ? DW'(i * 16'h0101) : 16'h0000;
            chk($sformatf("%s rsp_valid a%0d", tag, i), 32'(rsp_valid0), 32'd1);
            chk($sformatf("%s rdata0 a%0d", tag, i), 32'(rsp_rdata0), 32'(exp));
            chk($sformatf("%s rdata1 a%0d", tag, i), 32'(rsp_rdata1), 32'(exp));
        end
        idle();
        step();
        chk({tag, " rsp_valid after stream"}, 32'(rsp_valid0), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        //          we    addr    wdata     be     exp       act0     act1
        vt[0]  = '{1'b1, 6'h05, 16'hABCD, 2'b11, 16'h0000, 4'b0001, 4'b0010};
        vt[1]  = '{1'b1, 6'h05, 16'h1234, 2'b01, 16'h0000, 4'b0001, 4'b0010};
        vt[2]  = '{1'b0, 6'h05, 16'h0000, 2'b00, 16'hAB34, 4'b0001, 4'b0010};
        vt[3]  = '{1'b1, 6'h31, 16'h5A5A, 2'b11, 16'h0000, 4'b1000, 4'b0010};
        vt[4]  = '{1'b0, 6'h31, 16'h0000, 2'b00, 16'h5A5A, 4'b1000, 4'b0010};
        vt[5]  = '{1'b1, 6'h07, 16'h0777, 2'b11, 16'h0000, 4'b0001, 4'b1000};
        vt[6]  = '{1'b1, 6'h08, 16'h0888, 2'b11, 16'h0000, 4'b0001, 4'b0001};
        vt[7]  = '{1'b1, 6'h07, 16'hFFFF, 2'b00, 16'h0000, 4'b0001, 4'b1000};
        vt[8]  = '{1'b0, 6'h07, 16'h0000, 2'b00, 16'h0777, 4'b0001, 4'b1000};
        vt[9]  = '{1'b1, 6'h3F, 16'hC3FF, 2'b10, 16'h0000, 4'b1000, 4'b1000};
        vt[10] = '{1'b0, 6'h3F, 16'h0000, 2'b00, 16'hC300, 4'b1000, 4'b1000};
        vt[11] = '{1'b1, 6'h10, 16'hBEEF, 2'b11, 16'h0000, 4'b0010, 4'b0001};
        vt[12] = '{1'b0, 6'h10, 16'h0000, 2'b00, 16'hBEEF, 4'b0010, 4'b0001};

        // Reset state
        rst       = 1'b1;
        rsp_ready = 1'b1;
        idle();
        step();
        step();
        chk("reset req_ready", 32'(req_ready0), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid0), 32'd0);
        chk("reset rsp_rdata", 32'(rsp_rdata0), 32'd0);
        chk("reset init_done", 32'(init_done0), 32'd0);
        chk("reset bank_act", 32'(bank_act0), 32'd0);

        // Init sweep, then every word reads zero
        rst = 1'b0;
        wait_init("boot");
        stream_read(1'b0, "zero");

        // Table vectors: lanes, read-after-write, mapping, no-op write
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be);
            #1;
            chk($sformatf("vec%0d req_ready", i), 32'(req_ready0), 32'd1);
            step();
            idle();
            chk($sformatf("vec%0d bank_act0", i), 32'(bank_act0), 32'(vt[i].act0));
            chk($sformatf("vec%0d bank_act1", i), 32'(bank_act1), 32'(vt[i].act1));
            if (!vt[i].we) begin
                chk($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid0), 32'd1);
                chk($sformatf("vec%0d rdata0", i), 32'(rsp_rdata0), 32'(vt[i].exp));
                chk($sformatf("vec%0d rdata1", i), 32'(rsp_rdata1), 32'(vt[i].exp));
            end else begin
                chk($sformatf("vec%0d no rsp on write", i), 32'(rsp_valid0), 32'd0);
            end
        end

        // Back-pressure: response for addr 7 held 3 cycles, addr 8 read waits then follows with no gap
        drive(1'b0, 6'h07, 16'h0, 2'b00);
        step();
        drive(1'b0, 6'h08, 16'h0, 2'b00);
        rsp_ready = 1'b0;
        #1;
        chk("bp req_ready low", 32'(req_ready0), 32'd0);
        chk("bp rsp_valid first", 32'(rsp_valid0), 32'd1);
        chk("bp rdata first", 32'(rsp_rdata0), 32'h0777);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("bp hold%0d rsp_valid", c), 32'(rsp_valid0), 32'd1);
            chk($sformatf("bp hold%0d rdata", c), 32'(rsp_rdata0), 32'h0777);
            chk($sformatf("bp hold%0d req_ready", c), 32'(req_ready0), 32'd0);
            chk($sformatf("bp hold%0d bank_act", c), 32'(bank_act0), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp release req_ready", 32'(req_ready0), 32'd1);
        step();
        idle();
        chk("bp next rsp_valid", 32'(rsp_valid0), 32'd1);
        chk("bp next rdata", 32'(rsp_rdata0), 32'h0888);
        chk("bp next bank_act", 32'(bank_act0), 32'b0001);
        step();
        chk("bp drained rsp_valid", 32'(rsp_valid0), 32'd0);
        chk("bp rdata holds", 32'(rsp_rdata0), 32'h0888);

        // Streaming: fill every word, then read all back-to-back
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, AW'(i), {LW'(i), LW'(i)}, 2'b11);
            step();
        end
        idle();
        stream_read(1'b1, "stream");

        // Reset in the same cycle as a read, with a response already pending
        drive(1'b0, 6'h06, 16'h0, 2'b00);
        step();
        chk("pre-rst rsp_valid", 32'(rsp_valid0), 32'd1);
        chk("pre-rst rdata", 32'(rsp_rdata0), 32'h0606);
        rst = 1'b1;
        drive(1'b0, 6'h05, 16'h0, 2'b00);
        step();
        chk("rst rsp_valid", 32'(rsp_valid0), 32'd0);
        chk("rst rsp_rdata", 32'(rsp_rdata0), 32'd0);
        chk("rst init_done", 32'(init_done0), 32'd0);
        chk("rst bank_act", 32'(bank_act0), 32'd0);
        chk("rst req_ready", 32'(req_ready0), 32'd0);
        rst = 1'b0;
        wait_init("rerun");
        stream_read(1'b0, "post-rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
